decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Second pipeline stage of the 32-bit core, directly downstream of fetch.
- Consumes the fetch register outputs (instruction, PC+1, jump target).
- Reads the register file, detects load-use and jr hazards, resolves jal/jr in decode, and loads the D/X pipeline register for execute.
- Drives the fetch-side stall, redirect and flush controls.

Parameters:
- WIDTH, 32, datapath width
- RADDR, 5, register address width
- IMM_W, 17, immediate field width

Ports:
- clock  in  1  rising-edge clock
- aclr  in  1  asynchronous reset, active-high
- ins_in  in  32  instruction from fetch register
- pc_in  in  32  PC+1 from fetch register
- j_in  in  32  jump target from fetch register
- br_flush  in  1  branch taken in execute; squash decode
- rf_addr_a  out  5  regfile read port A address (rs)
- rf_addr_b  out  5  regfile read port B address (rt; rd for sw/jr)
- rf_data_a  in  32  read data A
- rf_data_b  in  32  read data B
- wb_we  in  1  writeback enable
- wb_addr  in  5  writeback address
- wb_data  in  32  writeback data
- stall_out  out  1  to fetch stallA; holds PC and fetch register
- jal_jr  out  1  redirect fetch
- jal_jr_val  out  32  redirect target
- jal_jr_clr  out  1  flush fetch register
- dx_pc, dx_a, dx_b, dx_imm  out  32 each  D/X register values
- dx_op  out  5  opcode
- dx_aluop  out  5  ALU op
- dx_shamt  out  5  shift amount
- dx_rd  out  5  destination
- dx_we  out  1  destination write enable
- dx_ld  out  1  instruction is lw

Behaviour:
- Field decode:
  - op=[31:27], rd=[26:22], rs=[21:17], rt=[16:12], shamt=[11:7], aluop=[6:2].
  - imm=[16:0], sign-extended to 32 bits.
- Opcodes:
  - 00000 R: reads rs, rt; writes rd.
  - 00001 j: no reads; no write.
  - 00011 jal: no reads; writes r31.
  - 00100 jr: reads rd.
  - 00101 addi: reads rs; writes rd.
  - 00111 sw: reads rs, rd; no write.
  - 01000 lw: reads rs; writes rd.
  - 00010/00110 branch: reads rd, rs; no write.
  - Any other opcode decodes as a nop (no reads, dx_we=0).
  - Writes to r0 never set dx_we.
- Pending-write tracker:
  - 3-entry shift register {valid, addr, is_ld} for the X, M and W stages.
  - Advances every clock; a bubble enters the X entry when decode does not issue.
- Hazard FSM states: RUN, LD_STALL, JR_WAIT.
  - RUN → LD_STALL: the X entry is a valid lw and its addr equals a read register of ins_in.
  - RUN → JR_WAIT: ins_in is jr and its rd matches any valid tracker entry.
  - LD_STALL: one bubble is issued; returns to RUN next cycle.
  - JR_WAIT: stays until there is no match, at most 3 cycles.
  - stall_out=1 in every cycle where the hazard condition holds.
  - While stalled, the D/X register loads a bubble: all controls 0, dx_op=0, dx_we=0.
- jal/jr redirect:
  - Asserted combinationally in the issuing cycle only, when no stall is active.
  - jal: jal_jr=1, jal_jr_val=j_in. At the clock edge, D/X receives dx_rd=31, dx_we=1, dx_a=pc_in as the link value.
  - jr: jal_jr=1, jal_jr_val=rf_data_b.
  - j is handled in fetch; decode treats it as a nop.
  - jal_jr_clr equals jal_jr.
- br_flush:
  - D/X loads a bubble and the FSM returns to RUN.
  - Suppresses stall_out and jal_jr that cycle.
  - Has priority over all other events.
- Latency: one cycle from ins_in to the D/X outputs.
- Reset (aclr):
  - All D/X outputs are 0, all tracker entries invalid, FSM in RUN.
  - stall_out, jal_jr and jal_jr_clr are 0 while aclr is high.

Optional Feature:
- DECODE_BYPASS_EN defined:
  - When wb_we=1, wb_addr≠0 and wb_addr equals a read address, the value used for that operand is wb_data instead of the rf_data value. This applies to dx_a/dx_b and to the jr target.
  - The tracker W entry is then ignored for jr hazard checks.
- Undefined: the regfile's write-before-read behaviour is relied on, and jr also waits on the W entry.

Decomposition:
- Shared package `cpu_pkg`: opcode constants, field bit positions, link register constant (31), bubble value of the D/X bundle.
- One sub-module: `hazard_tracker`, holding the tracker shift register plus the FSM and producing stall_out.

Test Plan:
- lw r3,0(r1) then add r4,r3,r2:
  - Exactly one stall_out cycle and one bubble (dx_we=0).
  - The add then appears with dx_rd=4.
- jal with j_in=0x00000040, pc_in=0x11:
  - Same cycle: jal_jr=1, jal_jr_val=0x40, jal_jr_clr=1.
  - Next cycle: dx_rd=31, dx_we=1, dx_a=0x11.
- addi r5,r0,7 then jr r5:
  - JR_WAIT, stall_out held until the r5 entry leaves the tracker (W ignored under DECODE_BYPASS_EN).
  - Then jal_jr=1 with jal_jr_val=7.
- br_flush=1 while a load-use stall is pending:
  - Bubble issued, stall_out=0, FSM returns to RUN.
- aclr pulsed mid-JR_WAIT:
  - All outputs 0 immediately (asynchronously); RUN after release.
- add r0,r1,r2 then add r6,r0,r0:
  - dx_we=0 for the first add; no stall.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode definitions: opcodes, instruction field positions,
// link register and the D/X pipeline bundle with its bubble value.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  localparam int OP_HI = 31;
  localparam int OP_LO = 27;
  localparam int RD_HI = 26;
  localparam int RD_LO = 22;
  localparam int RS_HI = 21;
  localparam int RS_LO = 17;
  localparam int RT_HI = 16;
  localparam int RT_LO = 12;
  localparam int SH_HI = 11;
  localparam int SH_LO = 7;
  localparam int AL_HI = 6;
  localparam int AL_LO = 2;

  localparam logic [4:0] OP_R    = 5'd0;
  localparam logic [4:0] OP_J    = 5'd1;
  localparam logic [4:0] OP_BEQ  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;

  localparam logic [RAW-1:0] LINK_REG = 5'd31;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [4:0]      op;
    logic [4:0]      aluop;
    logic [4:0]      shamt;
    logic [RAW-1:0]  rd;
    logic            we;
    logic            ld;
  } dx_t;

  localparam dx_t DX_BUBBLE = '0;

  typedef struct packed {
    logic           v;
    logic [RAW-1:0] addr;
    logic           ld;
  } trk_t;

endpackage

// File: rtl/hazard_tracker.sv
// Pending-write tracker (X/M/W) and load-use / jr hazard FSM.
// DECODE_BYPASS_EN: jr no longer waits on the W entry.
module hazard_tracker
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_flush,
  input  logic [RAW-1:0] i_ra,
  input  logic           i_ra_en,
  input  logic [RAW-1:0] i_rb,
  input  logic           i_rb_en,
  input  logic           i_jr,
  input  logic           i_we,
  input  logic [RAW-1:0] i_wa,
  input  logic           i_ld,
  output logic           o_stall,
  output logic           o_issue
);

  typedef enum logic [1:0] {RUN, LD_STALL, JR_WAIT} st_t;

  st_t  r_st, w_nxt;
  trk_t r_x, r_m, r_w, w_push;
  logic w_ld_hz, w_jr_hz, w_hz;

  function automatic logic hit(trk_t e, logic [RAW-1:0] a);
    return e.v && (e.addr == a);
  endfunction

  assign w_ld_hz = r_x.v && r_x.ld &&
                   ((i_ra_en && r_x.addr == i_ra) ||
                    (i_rb_en && r_x.addr == i_rb));

`ifdef DECODE_BYPASS_EN
  logic w_unused_w;
  assign w_unused_w = ^r_w;
  assign w_jr_hz = i_jr && (hit(r_x, i_rb) || hit(r_m, i_rb));
`else
  assign w_jr_hz = i_jr &&
                   (hit(r_x, i_rb) || hit(r_m, i_rb) || hit(r_w, i_rb));
`endif

  always_comb begin
    w_nxt = r_st;
    w_hz  = 1'b0;
    case (r_st)
      RUN: begin
        w_hz = w_ld_hz | w_jr_hz;
        if (w_ld_hz)      w_nxt = LD_STALL;
        else if (w_jr_hz) w_nxt = JR_WAIT;
      end
      LD_STALL: begin
        w_hz  = w_jr_hz;
        w_nxt = RUN;
      end
      JR_WAIT: begin
        w_hz = w_jr_hz;
        if (!w_jr_hz) w_nxt = RUN;
      end
      default: w_nxt = RUN;
    endcase
    // a taken branch squashes whatever decode holds
    if (i_flush) begin
      w_hz  = 1'b0;
      w_nxt = RUN;
    end
  end

  assign o_stall = w_hz & ~rst;
  assign o_issue = ~w_hz & ~i_flush & ~rst;

  always_comb begin
    w_push = '0;
    if (o_issue) begin
      w_push.v    = i_we;
      w_push.addr = i_wa;
      w_push.ld   = i_ld;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st <= RUN;
      r_x  <= '0;
      r_m  <= '0;
      r_w  <= '0;
    end else begin
      r_st <= w_nxt;
      r_x  <= w_push;
      r_m  <= r_x;
      r_w  <= r_m;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, regfile read, jal/jr redirect, D/X register.
// DECODE_BYPASS_EN: forward writeback data onto decode operands.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5,
  parameter int IMM_W = 17
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic [WIDTH-1:0] ins_in,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] j_in,
  input  logic             br_flush,
  output logic [RADDR-1:0] rf_addr_a,
  output logic [RADDR-1:0] rf_addr_b,
  input  logic [WIDTH-1:0] rf_data_a,
  input  logic [WIDTH-1:0] rf_data_b,
  input  logic             wb_we,
  input  logic [RADDR-1:0] wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             stall_out,
  output logic             jal_jr,
  output logic [WIDTH-1:0] jal_jr_val,
  output logic             jal_jr_clr,
  output logic [WIDTH-1:0] dx_pc,
  output logic [WIDTH-1:0] dx_a,
  output logic [WIDTH-1:0] dx_b,
  output logic [WIDTH-1:0] dx_imm,
  output logic [4:0]       dx_op,
  output logic [4:0]       dx_aluop,
  output logic [4:0]       dx_shamt,
  output logic [RADDR-1:0] dx_rd,
  output logic             dx_we,
  output logic             dx_ld
);

  logic [4:0]       w_op;
  logic [RADDR-1:0] w_rd, w_rs, w_rt, w_dest;
  logic [WIDTH-1:0] w_imm, w_opa, w_opb;
  logic w_a_en, w_b_en, w_b_rd, w_wr, w_ld, w_jal, w_jr, w_we, w_issue;
  dx_t  w_dx, r_dx;

  assign w_op  = ins_in[OP_HI:OP_LO];
  assign w_rd  = ins_in[RD_HI:RD_LO];
  assign w_rs  = ins_in[RS_HI:RS_LO];
  assign w_rt  = ins_in[RT_HI:RT_LO];
  assign w_imm = {{(WIDTH-IMM_W){ins_in[IMM_W-1]}}, ins_in[IMM_W-1:0]};

  always_comb begin
    w_a_en = 1'b0;
    w_b_en = 1'b0;
    w_b_rd = 1'b0;
    w_wr   = 1'b0;
    w_ld   = 1'b0;
    w_jal  = 1'b0;
    w_jr   = 1'b0;
    case (w_op)
      OP_R:    begin w_a_en = 1'b1; w_b_en = 1'b1; w_wr = 1'b1; end
      OP_J:    w_wr = 1'b0;
      OP_JAL:  begin w_wr = 1'b1; w_jal = 1'b1; end
      OP_JR:   begin w_b_en = 1'b1; w_b_rd = 1'b1; w_jr = 1'b1; end
      OP_ADDI: begin w_a_en = 1'b1; w_wr = 1'b1; end
      OP_SW:   begin w_a_en = 1'b1; w_b_en = 1'b1; w_b_rd = 1'b1; end
      OP_LW:   begin w_a_en = 1'b1; w_wr = 1'b1; w_ld = 1'b1; end
      OP_BEQ,
      OP_BLT:  begin w_a_en = 1'b1; w_b_en = 1'b1; w_b_rd = 1'b1; end
      default: w_wr = 1'b0;
    endcase
  end

  assign w_dest    = w_jal ? LINK_REG : w_rd;
  assign w_we      = w_wr && (w_dest != '0);
  assign rf_addr_a = w_rs;
  assign rf_addr_b = w_b_rd ? w_rd : w_rt;

`ifdef DECODE_BYPASS_EN
  logic w_byp_a, w_byp_b;
  assign w_byp_a = wb_we && (wb_addr != '0) && (wb_addr == rf_addr_a);
  assign w_byp_b = wb_we && (wb_addr != '0) && (wb_addr == rf_addr_b);
  assign w_opa   = w_byp_a ? wb_data : rf_data_a;
  assign w_opb   = w_byp_b ? wb_data : rf_data_b;
`else
  logic w_unused_wb;
  assign w_unused_wb = ^{wb_we, wb_addr, wb_data};
  assign w_opa = rf_data_a;
  assign w_opb = rf_data_b;
`endif

  hazard_tracker u_hz (
    .clk     (clock),
    .rst     (aclr),
    .i_flush (br_flush),
    .i_ra    (rf_addr_a),
    .i_ra_en (w_a_en),
    .i_rb    (rf_addr_b),
    .i_rb_en (w_b_en),
    .i_jr    (w_jr),
    .i_we    (w_we),
    .i_wa    (w_dest),
    .i_ld    (w_ld),
    .o_stall (stall_out),
    .o_issue (w_issue)
  );

  assign jal_jr     = w_issue & (w_jal | w_jr);
  assign jal_jr_val = w_jal ? j_in : w_opb;
  assign jal_jr_clr = jal_jr;

  always_comb begin
    w_dx = DX_BUBBLE;
    if (w_issue) begin
      w_dx.pc    = pc_in;
      w_dx.a     = w_jal ? pc_in : w_opa;
      w_dx.b     = w_opb;
      w_dx.imm   = w_imm;
      w_dx.op    = w_op;
      w_dx.aluop = ins_in[AL_HI:AL_LO];
      w_dx.shamt = ins_in[SH_HI:SH_LO];
      w_dx.rd    = w_dest;
      w_dx.we    = w_we;
      w_dx.ld    = w_ld;
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) r_dx <= DX_BUBBLE;
    else      r_dx <= w_dx;
  end

  assign dx_pc    = r_dx.pc;
  assign dx_a     = r_dx.a;
  assign dx_b     = r_dx.b;
  assign dx_imm   = r_dx.imm;
  assign dx_op    = r_dx.op;
  assign dx_aluop = r_dx.aluop;
  assign dx_shamt = r_dx.shamt;
  assign dx_rd    = r_dx.rd;
  assign dx_we    = r_dx.we;
  assign dx_ld    = r_dx.ld;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        aclr = 1'b0;
  logic [31:0] ins_in = 32'd0;
  logic [31:0] pc_in = 32'd0;
  logic [31:0] j_in = 32'd0;
  logic        br_flush = 1'b0;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [31:0] rf_data_a, rf_data_b;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        stall_out, jal_jr, jal_jr_clr;
  logic [31:0] jal_jr_val, dx_pc, dx_a, dx_b, dx_imm;
  logic [4:0]  dx_op, dx_aluop, dx_shamt, dx_rd;
  logic        dx_we, dx_ld;

  logic [31:0] rf [32];
  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'hF800_0000;

  always #5 clock = ~clock;

  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];

  decode_stage dut (
    .clock(clock), .aclr(aclr), .ins_in(ins_in), .pc_in(pc_in),
    .j_in(j_in), .br_flush(br_flush),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall_out(stall_out), .jal_jr(jal_jr),
    .jal_jr_val(jal_jr_val), .jal_jr_clr(jal_jr_clr),
    .dx_pc(dx_pc), .dx_a(dx_a), .dx_b(dx_b), .dx_imm(dx_imm),
    .dx_op(dx_op), .dx_aluop(dx_aluop), .dx_shamt(dx_shamt),
    .dx_rd(dx_rd), .dx_we(dx_we), .dx_ld(dx_ld)
  );

  function automatic logic [31:0] enc_r(logic [4:0] rd, rs, rt);
    return {5'd0, rd, rs, rt, 12'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [4:0] op, rd, rs,
                                        logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    ins_in = NOP;
    repeat (3) step();
  endtask

  task automatic test_reset();
    ins_in = {5'd3, 27'd0};
    #1 aclr = 1'b1;
    #1;
    checks++; if (dx_we !== 1'b0) begin failures++; $display("FAIL rst_dx_we got=%0b exp=0", dx_we); end
    checks++; if (dx_rd !== 5'd0) begin failures++; $display("FAIL rst_dx_rd got=%0d exp=0", dx_rd); end
    checks++; if (dx_a !== 32'd0) begin failures++; $display("FAIL rst_dx_a got=%h exp=0", dx_a); end
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", stall_out); end
    checks++; if (jal_jr !== 1'b0) begin failures++; $display("FAIL rst_jal_jr got=%0b exp=0", jal_jr); end
    checks++; if (jal_jr_clr !== 1'b0) begin failures++; $display("FAIL rst_clr got=%0b exp=0", jal_jr_clr); end
    step();
    aclr = 1'b0;
    drain();
  endtask

  task automatic test_load_use();
    ins_in = enc_i(5'd8, 5'd3, 5'd1, 17'd0);
    #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL lu_pre_stall got=%0b exp=0", stall_out); end
    step();
    checks++; if (dx_ld !== 1'b1 || dx_rd !== 5'd3 || dx_a !== 32'h101) begin failures++; $display("FAIL lu_lw ld=%0b rd=%0d a=%h exp 1/3/101", dx_ld, dx_rd, dx_a); end
    ins_in = enc_r(5'd4, 5'd3, 5'd2);
    #1;
    checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL lu_stall got=%0b exp=1", stall_out); end
    step();
    checks++; if (dx_we !== 1'b0 || dx_rd !== 5'd0) begin failures++; $display("FAIL lu_bubble we=%0b rd=%0d exp 0/0", dx_we, dx_rd); end
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL lu_one_stall got=%0b exp=0", stall_out); end
    step();
    checks++; if (dx_rd !== 5'd4 || dx_we !== 1'b1 || dx_a !== 32'h103 || dx_b !== 32'h102) begin failures++; $display("FAIL lu_add rd=%0d we=%0b a=%h b=%h", dx_rd, dx_we, dx_a, dx_b); end
    drain();
  endtask

  task automatic test_jal();
    ins_in = {5'd3, 27'd0};
    j_in = 32'h40;
    pc_in = 32'h11;
    #1;
    checks++; if (jal_jr !== 1'b1 || jal_jr_val !== 32'h40 || jal_jr_clr !== 1'b1) begin failures++; $display("FAIL jal_redirect jr=%0b val=%h clr=%0b exp 1/40/1", jal_jr, jal_jr_val, jal_jr_clr); end
    step();
    ins_in = NOP;
    checks++; if (dx_rd !== 5'd31 || dx_we !== 1'b1 || dx_a !== 32'h11) begin failures++; $display("FAIL jal_link rd=%0d we=%0b a=%h exp 31/1/11", dx_rd, dx_we, dx_a); end
    #1;
    checks++; if (jal_jr !== 1'b0) begin failures++; $display("FAIL jal_one_cycle got=%0b exp=0", jal_jr); end
    drain();
  endtask

  task automatic test_jr_wait();
    ins_in = enc_i(5'd5, 5'd5, 5'd0, 17'd7);
    step();
    checks++; if (dx_imm !== 32'd7 || dx_rd !== 5'd5 || dx_we !== 1'b1) begin failures++; $display("FAIL jr_addi imm=%h rd=%0d we=%0b", dx_imm, dx_rd, dx_we); end
    ins_in = {5'd4, 5'd5, 22'd0};
    #1;
    checks++; if (stall_out !== 1'b1 || jal_jr !== 1'b0) begin failures++; $display("FAIL jr_wait_x stall=%0b jr=%0b exp 1/0", stall_out, jal_jr); end
    step();
    checks++; if (dx_we !== 1'b0) begin failures++; $display("FAIL jr_bubble we=%0b exp=0", dx_we); end
    checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL jr_wait_m stall=%0b exp=1", stall_out); end
    step();
    wb_we = 1'b1;
    wb_addr = 5'd5;
    wb_data = 32'd7;
    #1;
`ifdef DECODE_BYPASS_EN
    checks++; if (stall_out !== 1'b0 || jal_jr !== 1'b1 || jal_jr_val !== 32'd7) begin failures++; $display("FAIL jr_byp stall=%0b jr=%0b val=%h exp 0/1/7", stall_out, jal_jr, jal_jr_val); end
    step();
    rf[5] = 32'd7;
    wb_we = 1'b0;
`else
    checks++; if (stall_out !== 1'b1) begin failures++; $display("FAIL jr_wait_w stall=%0b exp=1", stall_out); end
    step();
    rf[5] = 32'd7;
    wb_we = 1'b0;
    #1;
    checks++; if (stall_out !== 1'b0 || jal_jr !== 1'b1 || jal_jr_val !== 32'd7 || jal_jr_clr !== 1'b1) begin failures++; $display("FAIL jr_go stall=%0b jr=%0b val=%h exp 0/1/7", stall_out, jal_jr, jal_jr_val); end
    step();
`endif
    drain();
  endtask

  task automatic test_flush();
    ins_in = enc_i(5'd8, 5'd3, 5'd1, 17'd0);
    step();
    ins_in = enc_r(5'd4, 5'd3, 5'd2);
    br_flush = 1'b1;
    #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL fl_stall got=%0b exp=0", stall_out); end
    step();
    checks++; if (dx_we !== 1'b0 || dx_rd !== 5'd0) begin failures++; $display("FAIL fl_bubble we=%0b rd=%0d exp 0/0", dx_we, dx_rd); end
    ins_in = {5'd3, 27'd0};
    #1;
    checks++; if (jal_jr !== 1'b0 || jal_jr_clr !== 1'b0) begin failures++; $display("FAIL fl_jal jr=%0b clr=%0b exp 0/0", jal_jr, jal_jr_clr); end
    step();
    br_flush = 1'b0;
    ins_in = NOP;
    checks++; if (dx_we !== 1'b0) begin failures++; $display("FAIL fl_jal_bubble we=%0b exp=0", dx_we); end
    drain();
  endtask

  task automatic test_aclr_mid();
    ins_in = enc_i(5'd5, 5'd5, 5'd0, 17'd7);
    step();
    ins_in = {5'd4, 5'd5, 22'd0};
    #1;
    checks++; if (stall_out !== 1'b1 || dx_we !== 1'b1) begin failures++; $display("FAIL ar_pre stall=%0b we=%0b exp 1/1", stall_out, dx_we); end
    #2 aclr = 1'b1;
    #1;
    checks++; if (dx_we !== 1'b0 || dx_rd !== 5'd0 || dx_imm !== 32'd0) begin failures++; $display("FAIL ar_dx we=%0b rd=%0d imm=%h exp 0", dx_we, dx_rd, dx_imm); end
    checks++; if (stall_out !== 1'b0 || jal_jr !== 1'b0 || jal_jr_clr !== 1'b0) begin failures++; $display("FAIL ar_ctl stall=%0b jr=%0b clr=%0b exp 0", stall_out, jal_jr, jal_jr_clr); end
    step();
    aclr = 1'b0;
    #1;
    checks++; if (stall_out !== 1'b0 || jal_jr !== 1'b1 || jal_jr_val !== 32'd7) begin failures++; $display("FAIL ar_run stall=%0b jr=%0b val=%h exp 0/1/7", stall_out, jal_jr, jal_jr_val); end
    step();
    drain();
  endtask

  task automatic test_r0();
    ins_in = enc_r(5'd0, 5'd1, 5'd2);
    #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL r0_stall got=%0b exp=0", stall_out); end
    step();
    checks++; if (dx_we !== 1'b0 || dx_a !== 32'h101) begin failures++; $display("FAIL r0_we we=%0b a=%h exp 0/101", dx_we, dx_a); end
    ins_in = enc_r(5'd6, 5'd0, 5'd0);
    #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL r0_next_stall got=%0b exp=0", stall_out); end
    step();
    checks++; if (dx_we !== 1'b1 || dx_rd !== 5'd6) begin failures++; $display("FAIL r0_add6 we=%0b rd=%0d exp 1/6", dx_we, dx_rd); end
    drain();
  endtask

  task automatic test_back_to_back();
    ins_in = enc_i(5'd5, 5'd7, 5'd1, 17'h1FFFF);
    step();
    checks++; if (dx_imm !== 32'hFFFF_FFFF || dx_op !== 5'd5) begin failures++; $display("FAIL bb_sext imm=%h op=%0d exp ffffffff/5", dx_imm, dx_op); end
    ins_in = enc_r(5'd8, 5'd7, 5'd7);
    #1;
    checks++; if (stall_out !== 1'b0) begin failures++; $display("FAIL bb_nostall got=%0b exp=0", stall_out); end
    step();
    checks++; if (dx_rd !== 5'd8 || dx_we !== 1'b1) begin failures++; $display("FAIL bb_add rd=%0d we=%0b exp 8/1", dx_rd, dx_we); end
    ins_in = NOP;
    step();
    checks++; if (dx_we !== 1'b0) begin failures++; $display("FAIL bb_nop we=%0b exp=0", dx_we); end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h100 + i;
    test_reset();
    test_load_use();
    test_jal();
    test_jr_wait();
    test_flush();
    test_aclr_mid();
    test_r0();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
